// File: rtl/axi_stream_extract_header.sv
// Strips a 1..DATA_BYTE_WD byte header from each AXI-Stream packet, emits it on a
// side channel (LSB-aligned) and re-aligns the remaining payload to the MSB lane.
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    output logic                    valid_header,
    input  logic                    ready_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header
);
    localparam int CNT_W = BYTE_CNT_WD + 1;
    localparam int SH_W  = CNT_W + 3;
    localparam logic [CNT_W-1:0] BYTES = CNT_W'(DATA_BYTE_WD);

    typedef enum logic [1:0] {HDR, BODY, FLUSH} state_t;

    state_t                  state, state_nxt;
    logic                    active;
    logic [CNT_W-1:0]        h_q, h_in, h_cur, r_cur, n_in;
    logic [SH_W-1:0]         sh_h, sh_r;
    logic [DATA_WD-1:0]      res_q, pay_data;
    logic [DATA_BYTE_WD-1:0] flush_keep_q, res_keep, pay_keep;
    logic                    fire, long_last, hdr_free, pay_free;
    logic                    hdr_load, pay_load, pay_last;

    function automatic logic [CNT_W-1:0] byte_count(input logic [DATA_BYTE_WD-1:0] keep);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) cnt = cnt + CNT_W'(keep[i]);
        return cnt;
    endfunction

    // H comes straight from the input during the first beat, from the latch afterwards.
    assign h_in      = CNT_W'(byte_remove_cnt) + CNT_W'(1);
    assign h_cur     = (state == HDR) ? h_in : h_q;
    assign r_cur     = BYTES - h_cur;
    assign sh_h      = {h_cur, 3'b000};
    assign sh_r      = {r_cur, 3'b000};
    assign n_in      = byte_count(keep_in);
    assign long_last = last_in && (n_in > h_cur);
    assign res_keep  = ~({DATA_BYTE_WD{1'b1}} >> r_cur);
    assign hdr_free  = !valid_header || ready_header;
    assign pay_free  = !valid_out || ready_out;
    assign fire      = valid_in && ready_in;

    always_comb begin
        ready_in = 1'b0;
        case (state)
            HDR:     ready_in = active && hdr_free && pay_free;
            BODY:    ready_in = pay_free;
            default: ready_in = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HDR;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            active <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        hdr_load  = 1'b0;
        pay_load  = 1'b0;
        pay_last  = 1'b0;
        pay_data  = res_q;
        pay_keep  = flush_keep_q;
        case (state)
            HDR: begin
                pay_data = data_in << sh_h;
                pay_keep = keep_in << h_cur;
                if (fire) begin
                    hdr_load = 1'b1;
                    if (!last_in) begin
                        state_nxt = BODY;
                    end else if (long_last) begin
                        pay_load = 1'b1;
                        pay_last = 1'b1;
                    end
                end
            end
            BODY: begin
                pay_data = res_q | (data_in >> sh_r);
                pay_keep = res_keep | (keep_in >> r_cur);
                if (fire) begin
                    pay_load = 1'b1;
                    if (last_in) begin
                        pay_last  = !long_last;
                        state_nxt = long_last ? FLUSH : HDR;
                    end
                end
            end
            FLUSH: begin
                if (pay_free) begin
                    pay_load  = 1'b1;
                    pay_last  = 1'b1;
                    state_nxt = HDR;
                end
            end
            default: state_nxt = HDR;
        endcase
    end

    // Residue is kept MSB-aligned so it ORs directly onto the next beat's top H bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q          <= '0;
            res_q        <= '0;
            flush_keep_q <= '0;
        end else if (fire) begin
            res_q        <= data_in << sh_h;
            flush_keep_q <= keep_in << h_cur;
            if (hdr_load) h_q <= h_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else if (pay_load) begin
            valid_out <= 1'b1;
            data_out  <= pay_data;
            keep_out  <= pay_keep;
            last_out  <= pay_last;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
        end else if (hdr_load) begin
            valid_header <= 1'b1;
            data_header  <= data_in >> sh_r;
            keep_header  <= keep_in >> r_cur;
        end else if (ready_header) begin
            valid_header <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Bench for axi_stream_extract_header: directed vector table, corner sequences and
// randomized packets checked against a byte-level packet model.
module tb_axi_stream_extract_header;
    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        bit          in_vld;
        logic [31:0] din;
        logic [3:0]  kin;
        logic        lin;
        logic [1:0]  cnt;
        bit          pv;
        beat_t       pay;
        bit          hv;
        beat_t       hdr;
    } vec_t;

    logic        clk, rst_n;
    logic        valid_in, ready_in, last_in;
    logic [31:0] data_in, data_out, data_header;
    logic [3:0]  keep_in, keep_out, keep_header;
    logic [1:0]  byte_remove_cnt;
    logic        valid_out, ready_out, last_out, valid_header, ready_header;

    beat_t exp_pay[$];
    beat_t exp_hdr[$];
    vec_t  tbl[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    duty_out = 100;
    int    duty_hdr = 100;
    int    drv_limit = 2000;

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in),
        .last_in(last_in), .byte_remove_cnt(byte_remove_cnt),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .keep_out(keep_out), .last_out(last_out),
        .valid_header(valid_header), .ready_header(ready_header),
        .data_header(data_header), .keep_header(keep_header)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready_in"}, ready_in, 0);
        check({tag, "_valid_out"}, valid_out, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_keep_out"}, keep_out, 0);
        check({tag, "_last_out"}, last_out, 0);
        check({tag, "_valid_header"}, valid_header, 0);
        check({tag, "_data_header"}, data_header, 0);
        check({tag, "_keep_header"}, keep_header, 0);
    endtask

    initial begin
        ready_out = 1'b0;
        ready_header = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ready_out    = ($urandom_range(0, 99) < duty_out);
            ready_header = ($urandom_range(0, 99) < duty_hdr);
        end
    end

    // Output monitor: scoreboard compare on handshake, stability check under stall.
    initial begin
        logic  pv_prev, pr_prev, hv_prev, hr_prev;
        beat_t pb_prev, hb_prev, e;
        pv_prev = 0; pr_prev = 0; hv_prev = 0; hr_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv_prev = 0;
                hv_prev = 0;
            end else begin
                if (pv_prev && !pr_prev) begin
                    check("pay_stall_valid", valid_out, 1);
                    check("pay_stall_data", data_out, pb_prev.data);
                    check("pay_stall_keep_last", {keep_out, last_out}, {pb_prev.keep, pb_prev.last});
                end
                if (hv_prev && !hr_prev) begin
                    check("hdr_stall_valid", valid_header, 1);
                    check("hdr_stall_data", data_header, hb_prev.data);
                    check("hdr_stall_keep", keep_header, hb_prev.keep);
                end
                if (valid_out && ready_out) begin
                    if (exp_pay.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL pay_unexpected: got beat %h/%b last %0b, required no beat",
                                 data_out, keep_out, last_out);
                    end else begin
                        e = exp_pay.pop_front();
                        check("pay_keep", keep_out, e.keep);
                        check("pay_last", last_out, e.last);
                        check("pay_data", data_out & lane_mask(e.keep), e.data & lane_mask(e.keep));
                    end
                end
                if (valid_header && ready_header) begin
                    if (exp_hdr.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL hdr_unexpected: got header %h/%b, required no header",
                                 data_header, keep_header);
                    end else begin
                        e = exp_hdr.pop_front();
                        check("hdr_keep", keep_header, e.keep);
                        check("hdr_data", data_header & lane_mask(e.keep), e.data & lane_mask(e.keep));
                    end
                end
                pv_prev = valid_out;
                pr_prev = ready_out;
                pb_prev = '{data_out, keep_out, last_out};
                hv_prev = valid_header;
                hr_prev = ready_header;
                hb_prev = '{data_header, keep_header, 1'b0};
            end
        end
    end

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                              input logic [1:0] c);
        int t;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l; byte_remove_cnt = c;
        t = 0;
        @(negedge clk);
        while (!ready_in && t < drv_limit) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!ready_in) begin
            n_fail++;
            $display("FAIL in_handshake: ready_in %0b after %0d cycles, required 1", ready_in, t);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Reference model: header = first min(H,L) bytes placed at lanes H-1 downward;
    // payload = remaining bytes packed MSB-first into 4-byte beats.
    task automatic send_pkt(input int h, input int len);
        logic [7:0]  b[$];
        beat_t       e;
        logic [31:0] d;
        logic [3:0]  kk;
        int          k, plen, nb, idx;
        for (int i = 0; i < len; i++) b.push_back(8'($urandom));
        e = '{32'h0, 4'h0, 1'b0};
        k = (len < h) ? len : h;
        for (int j = 0; j < k; j++) begin
            e.data[8*(h-1-j) +: 8] = b[j];
            e.keep[h-1-j] = 1'b1;
        end
        exp_hdr.push_back(e);
        plen = len - h;
        for (int p = 0; p < plen; p += 4) begin
            e = '{32'h0, 4'h0, 1'b0};
            for (int j = 0; j < 4; j++) begin
                if (p + j < plen) begin
                    e.data[31-8*j -: 8] = b[h+p+j];
                    e.keep[3-j] = 1'b1;
                end
            end
            e.last = (p + 4 >= plen);
            exp_pay.push_back(e);
        end
        nb = (len + 3) / 4;
        for (int bi = 0; bi < nb; bi++) begin
            d = $urandom;
            kk = 4'h0;
            for (int j = 0; j < 4; j++) begin
                idx = 4 * bi + j;
                if (idx < len) begin
                    d[31-8*j -: 8] = b[idx];
                    kk[3-j] = 1'b1;
                end
            end
            drive_beat(d, kk, bi == nb - 1, (bi == 0) ? 2'(h - 1) : 2'($urandom));
        end
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int t;
        t = 0;
        while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && t < limit) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_pay_pending"}, exp_pay.size(), 0);
        check({tag, "_hdr_pending"}, exp_hdr.size(), 0);
    endtask

    function automatic vec_t mk(bit iv, logic [31:0] d, logic [3:0] k, logic l, logic [1:0] c,
                                bit pv, logic [31:0] pd, logic [3:0] pk, logic pl,
                                bit hv, logic [31:0] hd, logic [3:0] hk);
        vec_t v;
        v.in_vld = iv; v.din = d; v.kin = k; v.lin = l; v.cnt = c;
        v.pv = pv; v.pay = '{pd, pk, pl};
        v.hv = hv; v.hdr = '{hd, hk, 1'b0};
        return v;
    endfunction

    initial begin
        // H=1: three full beats, last beat spills into a flush beat
        tbl.push_back(mk(1, 32'hAABBCCDD, 4'b1111, 0, 2'd0, 0, 0, 0, 0, 1, 32'h000000AA, 4'b0001));
        tbl.push_back(mk(1, 32'h11223344, 4'b1111, 0, 2'd3, 1, 32'hBBCCDD11, 4'b1111, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h55667788, 4'b1111, 1, 2'd2, 1, 32'h22334455, 4'b1111, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h66778800, 4'b1110, 1, 0, 0, 0));
        // H=2: last beat fits, no flush
        tbl.push_back(mk(1, 32'hA1A2A3A4, 4'b1111, 0, 2'd1, 0, 0, 0, 0, 1, 32'h0000A1A2, 4'b0011));
        tbl.push_back(mk(1, 32'hB1B2B3B4, 4'b1111, 0, 2'd0, 1, 32'hA3A4B1B2, 4'b1111, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'hC1C2DEAD, 4'b1100, 1, 2'd3, 1, 32'hB3B4C1C2, 4'b1111, 1, 0, 0, 0));
        // H=4: pass-through
        tbl.push_back(mk(1, 32'h01020304, 4'b1111, 0, 2'd3, 0, 0, 0, 0, 1, 32'h01020304, 4'b1111));
        tbl.push_back(mk(1, 32'h05060708, 4'b1111, 0, 2'd1, 1, 32'h05060708, 4'b1111, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h090A0B0C, 4'b1111, 1, 2'd0, 1, 32'h090A0B0C, 4'b1111, 1, 0, 0, 0));
        // H=2 single-beat packets
        tbl.push_back(mk(1, 32'hA1A2A3A4, 4'b1111, 1, 2'd1, 1, 32'hA3A40000, 4'b1100, 1, 1, 32'h0000A1A2, 4'b0011));
        tbl.push_back(mk(1, 32'hA1A2A3A4, 4'b1000, 1, 2'd1, 0, 0, 0, 0, 1, 32'h0000A100, 4'b0010));

        rst_n = 1'b0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0; byte_remove_cnt = '0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].hv) exp_hdr.push_back(tbl[i].hdr);
            if (tbl[i].pv) exp_pay.push_back(tbl[i].pay);
            if (tbl[i].in_vld) drive_beat(tbl[i].din, tbl[i].kin, tbl[i].lin, tbl[i].cnt);
        end
        wait_drain("directed", 200);

        // Pending header must not stall the body, only the next packet's first beat.
        duty_hdr = 0;
        drv_limit = 20;
        send_pkt(1, 10);
        repeat (4) @(posedge clk);
        #1;
        check("hdr_block_valid_header", valid_header, 1);
        check("hdr_block_ready_in", ready_in, 0);
        duty_hdr = 100;
        drv_limit = 2000;
        wait_drain("hdr_block", 200);

        // Reset in the middle of a packet body
        duty_out = 0;
        duty_hdr = 0;
        repeat (2) @(posedge clk);
        #2;
        drive_beat(32'h11111111, 4'b1111, 0, 2'd0);
        drive_beat(32'h22222222, 4'b1111, 0, 2'd2);
        check("midreset_valid_out", valid_out, 1);
        check("midreset_valid_header", valid_header, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_pay.delete();
        exp_hdr.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        duty_out = 100;
        duty_hdr = 100;
        @(posedge clk);
        #1;
        send_pkt(3, 7);
        wait_drain("post_reset", 200);

        // Randomized back-to-back packets with throttled consumers
        duty_out = 20;
        duty_hdr = 20;
        for (int p = 0; p < 40; p++) send_pkt($urandom_range(1, 4), $urandom_range(1, 13));
        wait_drain("random", 20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
